clk_div_multi: RTL and testbench

Multi-channel, runtime-programmable clock/tick divider, the parametrised successor of the single fixed-modulus divider. It produces `CHANNELS` independent divided outputs from one system clock, each with its own enable, divisor and mode (50 % toggle or one-cycle pulse). A write port reloads divisors glitch-free at the next terminal count. It feeds display multiplexing, debouncers and counter timebases from a single module.

---
 rtl/clk_div_multi.sv | 133 +++++++++++++
 tb/tb_clk_div_multi.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi
//   Multi-channel runtime-programmable clock/tick divider. Each channel counts
//   enabled clk cycles up to its active divisor and produces either a 50 %
//   toggle output (period 2*D) or a one-cycle pulse (period D), plus a
//   one-cycle terminal-count tick. New divisor/mode settings are staged as
//   "pending" and only take effect on a terminal count, or on the next edge
//   when the channel is disabled, so running outputs never glitch.
//
// Ports
//   clk       : system clock, rising edge only
//   reset     : asynchronous, active-high
//   enable    : per-channel count enable
//   cfg_we    : one-cycle configuration write strobe
//   cfg_ch    : target channel of the write
//   cfg_div   : new divisor (0 is rejected)
//   cfg_mode  : 0 = toggle, 1 = pulse
//   div_out   : registered divided output per channel
//   tick      : registered one-cycle terminal-count strobe per channel
//   pending   : channel holds an accepted, not yet applied configuration
//   cfg_err   : one-cycle strobe after a rejected write
module clk_div_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_mode,
  output logic [CHANNELS-1:0] div_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending,
  output logic                cfg_err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0]    cnt      [CHANNELS];
  logic [WIDTH-1:0]    act_div  [CHANNELS];
  logic [WIDTH-1:0]    pend_div [CHANNELS];
  logic [CHANNELS-1:0] act_mode;
  logic [CHANNELS-1:0] pend_mode;

  logic [CHANNELS-1:0] tc;
  logic [CHANNELS-1:0] sel;
  logic [CHANNELS-1:0] apply;
  logic [CHANNELS-1:0] mode_chg;
  logic                cfg_bad;
  logic                cfg_ok;

  always_comb begin
    tc       = '0;
    sel      = '0;
    apply    = '0;
    mode_chg = '0;
    // Channel range check done in 32-bit so it stays meaningful when
    // CHANNELS is not a power of two.
    cfg_bad  = (cfg_div == '0) || (int'(cfg_ch) >= CHANNELS);
    cfg_ok   = cfg_we && !cfg_bad;
    for (int i = 0; i < CHANNELS; i++) begin
      tc[i]       = enable[i] && (cnt[i] == act_div[i] - ONE);
      sel[i]      = cfg_ok && (cfg_ch == CH_W'(i));
      // A disabled channel has no TC to wait for, so it applies at once.
      apply[i]    = pending[i] && (tc[i] || !enable[i]);
      mode_chg[i] = pend_mode[i] ^ act_mode[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i]      <= '0;
        act_div[i]  <= DEF;
        pend_div[i] <= DEF;
      end
      act_mode  <= '0;
      pend_mode <= '0;
      div_out   <= '0;
      tick      <= '0;
      pending   <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_we && cfg_bad;
      for (int i = 0; i < CHANNELS; i++) begin
        if (tc[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b1;
          if (apply[i] && mode_chg[i]) begin
            div_out[i] <= 1'b0;
          end else if (act_mode[i]) begin
            div_out[i] <= 1'b1;
          end else begin
            div_out[i] <= ~div_out[i];
          end
        end else if (enable[i]) begin
          cnt[i]  <= cnt[i] + ONE;
          tick[i] <= 1'b0;
          if (act_mode[i]) begin
            div_out[i] <= 1'b0;
          end
        end else begin
          tick[i] <= 1'b0;
          if (apply[i]) begin
            cnt[i] <= '0;
          end
          if (act_mode[i] || (apply[i] && mode_chg[i])) begin
            div_out[i] <= 1'b0;
          end
        end

        if (apply[i]) begin
          act_div[i]  <= pend_div[i];
          act_mode[i] <= pend_mode[i];
          pending[i]  <= 1'b0;
        end

        // A write landing on the apply edge is kept for the next TC; the
        // apply above already used the previous pending values.
        if (sel[i]) begin
          pend_div[i]  <= cfg_div;
          pend_mode[i] <= cfg_mode;
          pending[i]   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi
//   Directed bench for clk_div_multi (4 channels, 16-bit, default divisor 10).
//   Expected output values are queued against an absolute cycle number when
//   the stimulus is planned; a negedge monitor pops and compares them.
//   Cycle n means "outputs after the n-th rising edge following reset release".
module tb_clk_div_multi;

  localparam int CHANNELS = 4;
  localparam int WIDTH    = 16;

  localparam int S_TICK = 0;
  localparam int S_DIV  = 1;
  localparam int S_PEND = 2;
  localparam int S_ERR  = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [CHANNELS-1:0] enable = '0;
  logic                cfg_we = 1'b0;
  logic [1:0]          cfg_ch = '0;
  logic [WIDTH-1:0]    cfg_div = '0;
  logic                cfg_mode = 1'b0;
  logic [CHANNELS-1:0] div_out;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] pending;
  logic                cfg_err;

  clk_div_multi #(
    .CHANNELS    (CHANNELS),
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .div_out  (div_out),
    .tick     (tick),
    .pending  (pending),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    string      tag;
    int         at;
    int         sig;
    logic [3:0] mask;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input string tag, input int at, input int sig,
                           input logic [3:0] mask, input logic [3:0] val);
    exp_t e;
    e.tag  = tag;
    e.at   = at;
    e.sig  = sig;
    e.mask = mask;
    e.val  = val;
    sb.push_back(e);
  endtask

  function automatic logic [3:0] pick(input int s);
    case (s)
      S_TICK:  return tick;
      S_DIV:   return div_out;
      S_PEND:  return pending;
      default: return {3'b000, cfg_err};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].at == cyc) begin
          check($sformatf("%s@%0d", sb[k].tag, cyc),
                pick(sb[k].sig) & sb[k].mask, sb[k].val & sb[k].mask);
          sb.delete(k);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Strobe held for exactly one rising edge.
  task automatic write_cfg(input int ch, input int d, input logic m);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_div  = 16'(d);
    cfg_mode = m;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_tick", tick, 4'h0);
    check("rst_div",  div_out, 4'h0);
    check("rst_pend", pending, 4'h0);
    check("rst_err",  {3'b000, cfg_err}, 4'h0);

    enable = 4'hF;
    reset  = 1'b0;

    // Default divisor, and ch1 reload to D=3 written during cycle 14
    expect_at("def_tick", 9,  S_TICK, 4'hF, 4'h0);
    expect_at("def_tick", 10, S_TICK, 4'hF, 4'hF);
    expect_at("def_div",  10, S_DIV,  4'hF, 4'hF);
    expect_at("def_tick", 11, S_TICK, 4'hF, 4'h0);
    expect_at("rl_pend",  14, S_PEND, 4'hF, 4'h0);
    expect_at("rl_pend",  15, S_PEND, 4'hF, 4'h2);
    expect_at("rl_pend",  19, S_PEND, 4'hF, 4'h2);
    expect_at("def_div",  19, S_DIV,  4'hF, 4'hF);
    expect_at("def_tick", 20, S_TICK, 4'hF, 4'hF);
    expect_at("def_div",  20, S_DIV,  4'hF, 4'h0);
    expect_at("rl_pend",  20, S_PEND, 4'hF, 4'h0);
    expect_at("def_tick", 21, S_TICK, 4'hF, 4'h0);
    expect_at("rl_div",   22, S_DIV,  4'h2, 4'h0);
    expect_at("rl_tick",  23, S_TICK, 4'hF, 4'h2);
    expect_at("rl_div",   23, S_DIV,  4'h2, 4'h2);
    expect_at("rl_tick",  26, S_TICK, 4'h2, 4'h2);
    expect_at("rl_div",   26, S_DIV,  4'h2, 4'h0);
    expect_at("rl_tick",  29, S_TICK, 4'hF, 4'h2);
    expect_at("def_tick", 30, S_TICK, 4'hF, 4'hD);
    expect_at("def_div",  30, S_DIV,  4'hF, 4'hF);

    // ch2 pulse mode D=1, then D=4, then disable
    expect_at("p1_pend",  32, S_PEND, 4'h4, 4'h4);
    expect_at("p1_pend",  39, S_PEND, 4'h4, 4'h4);
    expect_at("p1_tick",  40, S_TICK, 4'hF, 4'hD);
    expect_at("p1_mchg",  40, S_DIV,  4'h4, 4'h0);
    expect_at("p1_pend",  40, S_PEND, 4'h4, 4'h0);
    expect_at("p1_div",   41, S_DIV,  4'h4, 4'h4);
    expect_at("p1_tick",  41, S_TICK, 4'h4, 4'h4);
    expect_at("p1_div",   45, S_DIV,  4'h4, 4'h4);
    expect_at("p1_tick",  45, S_TICK, 4'h4, 4'h4);
    expect_at("p1_div",   50, S_DIV,  4'h4, 4'h4);
    expect_at("p4_pend",  51, S_PEND, 4'h4, 4'h4);
    expect_at("p4_tick",  51, S_TICK, 4'h4, 4'h4);
    expect_at("p4_pend",  52, S_PEND, 4'h4, 4'h0);
    expect_at("p4_div",   52, S_DIV,  4'h4, 4'h4);
    expect_at("p4_div",   53, S_DIV,  4'h4, 4'h0);
    expect_at("p4_tick",  53, S_TICK, 4'h4, 4'h0);
    expect_at("p4_div",   55, S_DIV,  4'h4, 4'h0);
    expect_at("p4_div",   56, S_DIV,  4'h4, 4'h4);
    expect_at("p4_tick",  56, S_TICK, 4'h4, 4'h4);
    expect_at("p4_div",   57, S_DIV,  4'h4, 4'h0);
    expect_at("p4_div",   60, S_DIV,  4'h4, 4'h4);
    expect_at("p4_div",   64, S_DIV,  4'h4, 4'h4);
    expect_at("dis_div",  65, S_DIV,  4'h4, 4'h0);
    expect_at("dis_tick", 65, S_TICK, 4'h4, 4'h0);
    expect_at("dis_div",  66, S_DIV,  4'h4, 4'h0);

    // Disabled-channel apply of D=5 toggle, then re-enable
    expect_at("dap_pend", 68, S_PEND, 4'h4, 4'h4);
    expect_at("dap_pend", 69, S_PEND, 4'h4, 4'h0);
    expect_at("dap_div",  69, S_DIV,  4'h4, 4'h0);
    expect_at("d5_tick",  74, S_TICK, 4'h4, 4'h0);
    expect_at("d5_tick",  75, S_TICK, 4'h4, 4'h4);
    expect_at("d5_div",   75, S_DIV,  4'h4, 4'h4);
    expect_at("d5_div",   79, S_DIV,  4'h4, 4'h4);
    expect_at("d5_tick",  80, S_TICK, 4'h4, 4'h4);
    expect_at("d5_div",   80, S_DIV,  4'h5, 4'h0);

    // Rejected writes (divisor 0 on ch0 and on ch3)
    expect_at("rej_err",  76, S_ERR,  4'h1, 4'h0);
    expect_at("rej_err",  77, S_ERR,  4'h1, 4'h1);
    expect_at("rej_pend", 77, S_PEND, 4'hF, 4'h0);
    expect_at("rej_err",  78, S_ERR,  4'h1, 4'h0);
    expect_at("rej_err",  79, S_ERR,  4'h1, 4'h1);
    expect_at("rej_pend", 79, S_PEND, 4'hF, 4'h0);
    expect_at("rej_err",  80, S_ERR,  4'h1, 4'h0);
    expect_at("rej_tick", 79, S_TICK, 4'h1, 4'h0);
    expect_at("rej_tick", 80, S_TICK, 4'h1, 4'h1);

    // Write to ch0 on the same edge as its TC
    expect_at("sim_tick", 90,  S_TICK, 4'h1, 4'h1);
    expect_at("sim_pend", 90,  S_PEND, 4'h1, 4'h1);
    expect_at("sim_tick", 94,  S_TICK, 4'h1, 4'h0);
    expect_at("sim_pend", 99,  S_PEND, 4'h1, 4'h1);
    expect_at("sim_tick", 100, S_TICK, 4'h1, 4'h1);
    expect_at("sim_pend", 100, S_PEND, 4'h1, 4'h0);
    expect_at("sim_tick", 103, S_TICK, 4'h1, 4'h0);
    expect_at("sim_tick", 104, S_TICK, 4'h1, 4'h1);
    expect_at("sim_tick", 108, S_TICK, 4'h1, 4'h1);

    // Back-to-back writes to ch3: only D=3 is applied
    expect_at("b2b_tick", 110, S_TICK, 4'h8, 4'h8);
    expect_at("b2b_pend", 112, S_PEND, 4'h8, 4'h8);
    expect_at("b2b_pend", 119, S_PEND, 4'h8, 4'h8);
    expect_at("b2b_tick", 120, S_TICK, 4'h8, 4'h8);
    expect_at("b2b_pend", 120, S_PEND, 4'h8, 4'h0);
    expect_at("b2b_tick", 122, S_TICK, 4'h8, 4'h0);
    expect_at("b2b_tick", 123, S_TICK, 4'h8, 4'h8);
    expect_at("b2b_tick", 126, S_TICK, 4'h8, 4'h8);

    // State just before the asynchronous reset
    expect_at("pre_div",  129, S_DIV,  4'h1, 4'h1);
    expect_at("pre_pend", 129, S_PEND, 4'h1, 4'h1);

    wait_cyc(14);  write_cfg(1, 3, 1'b0);
    wait_cyc(31);  write_cfg(2, 1, 1'b1);
    wait_cyc(50);  write_cfg(2, 4, 1'b1);
    wait_cyc(64);  enable = 4'b1011;
    wait_cyc(67);  write_cfg(2, 5, 1'b0);
    wait_cyc(70);  enable = 4'hF;
    wait_cyc(76);  write_cfg(0, 0, 1'b1);
    wait_cyc(78);  write_cfg(3, 0, 1'b0);
    wait_cyc(89);  write_cfg(0, 4, 1'b0);
    wait_cyc(111); write_cfg(3, 2, 1'b0); write_cfg(3, 3, 1'b0);
    wait_cyc(128); write_cfg(0, 7, 1'b0);
    wait_cyc(130);

    reset = 1'b1;
    #1;
    check("arst_div",  div_out, 4'h0);
    check("arst_tick", tick, 4'h0);
    check("arst_pend", pending, 4'h0);
    check("arst_err",  {3'b000, cfg_err}, 4'h0);
    @(negedge clk);
    reset = 1'b0;

    // Reset at cycle 7 of a D=10 count with ch1 pending
    expect_at("mid_pend", 4, S_PEND, 4'hF, 4'h2);
    expect_at("mid_pend", 6, S_PEND, 4'hF, 4'h2);
    wait_cyc(3); write_cfg(1, 3, 1'b0);
    wait_cyc(7);
    reset = 1'b1;
    #1;
    check("mrst_div",  div_out, 4'h0);
    check("mrst_tick", tick, 4'h0);
    check("mrst_pend", pending, 4'h0);
    @(negedge clk);
    reset = 1'b0;

    expect_at("post_tick", 3,  S_TICK, 4'hF, 4'h0);
    expect_at("post_pend", 5,  S_PEND, 4'hF, 4'h0);
    expect_at("post_tick", 6,  S_TICK, 4'h2, 4'h0);
    expect_at("post_tick", 9,  S_TICK, 4'hF, 4'h0);
    expect_at("post_tick", 10, S_TICK, 4'hF, 4'hF);
    expect_at("post_div",  10, S_DIV,  4'hF, 4'hF);
    expect_at("post_tick", 11, S_TICK, 4'hF, 4'h0);
    expect_at("post_div",  19, S_DIV,  4'hF, 4'hF);
    expect_at("post_tick", 20, S_TICK, 4'hF, 4'hF);
    expect_at("post_div",  20, S_DIV,  4'hF, 4'h0);

    wait_cyc(22);
    @(negedge clk);

    while (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: never observed at cycle %0d", sb[0].tag, sb[0].at);
      void'(sb.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
